uart_io_unit: RTL and testbench
===============================

Name: uart_io_unit

Overview:
- Buffered UART byte-stream front end for the execute stage; services core IN/OUT instructions.
- Generalised successor of the single-byte IN/OUT path:
  - parametrised RX/TX FIFO depths
  - multi-byte (1..BYTES_MAX) little-endian word transfers
  - full/overflow status
  - explicit done handshake
- Sits between the core and the existing uart_rx/uart_tx byte engines, which are instantiated alongside it.

Parameters:
RX_DEPTH_LOG2, 14, log2 of RX FIFO depth in bytes
TX_DEPTH_LOG2, 12, log2 of TX FIFO depth in bytes
BYTES_MAX, 4, maximum bytes per IN/OUT word (1..4)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
mode  in  3  1=LOAD, 2=EXEC, other=idle
in_req  in  1  start IN transfer (one-cycle pulse)
out_req  in  1  start OUT transfer (one-cycle pulse)
nbytes  in  3  bytes for this transfer, sampled with req
out_data  in  32  OUT word, sampled with out_req
in_data  out  32  assembled IN word
busy  out  1  transfer in progress (stall core)
done  out  1  one-cycle pulse, transfer complete
rx_data  in  8  byte from uart_rx
rx_ready  in  1  rx_data valid, one cycle
tx_data  out  8  byte to uart_tx
tx_start  out  1  uart_tx start pulse
tx_busy  in  1  uart_tx busy
aa_received  out  1  rx_ready && rx_data==8'hAA (combinational, any mode)
aa_sent  out  1  sticky: LOAD sync byte fully transmitted
rx_overflow  out  1  sticky: RX byte dropped on full FIFO
rx_count  out  RX_DEPTH_LOG2+1  RX FIFO occupancy
tx_full  out  1  TX FIFO full

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high (rst).
  - On reset all registered outputs go to 0, FIFO pointers/counts to 0, FSMs to IDLE.
  - Reset mid-transfer abandons the transfer and discards FIFO contents.
- nbytes normalisation: 0 is treated as 1; values >BYTES_MAX clamp to BYTES_MAX; the value is latched as n.
- Core FSM states: IDLE, IN_COLLECT, OUT_PUSH.
  - IDLE:
    - in_req goes to IN_COLLECT.
    - otherwise out_req goes to OUT_PUSH and latches out_data.
    - If both are asserted, in_req wins and out_req is dropped.
    - Requests outside IDLE are ignored.
  - IN_COLLECT:
    - Each cycle the RX FIFO is non-empty, pop one byte into lane k (bits 8k+7:8k), k=0..n-1.
    - After the n-th pop, upper lanes are zeroed, in_data updates, done=1 for one cycle, return to IDLE.
    - in_data holds until the next IN completes.
  - OUT_PUSH:
    - Each cycle the TX FIFO is not full and no LOAD sync push is occurring, push byte k of the latched word.
    - After n pushes, done pulses and the FSM returns to IDLE.
- busy = (IDLE && (in_req||out_req)) || state!=IDLE.
  - busy is low in the cycle done is high.
  - Minimum latency: done n cycles after req.
- RX capture:
  - When mode==2 && rx_ready, push rx_data.
  - If the FIFO is full (count==2^RX_DEPTH_LOG2), drop the byte and set rx_overflow (sticky until rst).
  - Push and pop in the same cycle leave count unchanged; this also holds when full, since the pop frees the slot and the byte is accepted.
- LOAD sync:
  - When mode==1 and the internal aa_queued==0, push 8'hAA once and set aa_queued.
  - This push has priority over an OUT push in the same cycle; the OUT push stalls one cycle.
  - aa_sent sets when aa_queued && TX FIFO empty && !tx_busy && TX FSM idle. It is sticky.
- TX drain FSM states: T_IDLE, T_START, T_WAIT.
  - T_IDLE: if FIFO non-empty && !tx_busy, register the head into tx_data, pop, go to T_START.
  - T_START: tx_start=1 for exactly one cycle, go to T_WAIT.
  - T_WAIT: one cycle to let tx_busy rise, then T_IDLE.
  - tx_data is stable from T_START until the next pop.
- Pointers wrap modulo depth.
  - Full/empty are derived from the count register (width LOG2+1), never from pointer equality alone.

Decomposition:
- Shared package:
  - MODE_LOAD=3'd1, MODE_EXEC=3'd2
  - SYNC_BYTE=8'hAA
  - core_state_t and tx_state_t enums
- Sub-module sync_fifo:
  - parameters WIDTH, DEPTH_LOG2
  - ports: push/pop/din/dout/count/full/empty, async active-high rst
  - instantiated twice (RX, TX).

Test Plan:
- Drive rx bytes 0x11,0x22,0x33,0x44 in mode 2, then in_req with nbytes=4 -> in_data=0x44332211, done one cycle after 4th pop, busy low on done.
- out_req, out_data=0xA1B2C3D4, nbytes=2 -> tx_start pulses carry 0xD4 then 0xC3, each only after tx_busy falls; exactly 2 tx_start pulses.
- mode=1 from reset -> first tx_data=0xAA; aa_sent rises only after tx_busy falls with the FIFO empty; no second 0xAA.
- RX_DEPTH_LOG2=2: push 5 bytes with no pop -> rx_count=4, rx_overflow=1, then in_req nbytes=4 returns the first 4 bytes.
- in_req and out_req same cycle, nbytes=0 -> IN of 1 byte performed, no TX push.
- Assert rst mid IN_COLLECT (2 of 4 bytes popped) -> outputs 0 immediately (async), rx_count=0, next in_req waits for new bytes.

Source files
------------

// File: rtl/uart_io_unit_pkg.sv
// ---------------------------------------------------------------------------
// uart_io_unit_pkg
// Shared definitions for the buffered UART IN/OUT front end: mode encodings,
// the LOAD sync byte, the core and TX-drain FSM state types and the
// transfer-length normalisation helper.
// ---------------------------------------------------------------------------
package uart_io_unit_pkg;

    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_EXEC = 3'd2;
    localparam logic [7:0] SYNC_BYTE = 8'hAA;

    typedef enum logic [1:0] {
        IDLE,
        IN_COLLECT,
        OUT_PUSH
    } core_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_START,
        T_WAIT
    } tx_state_t;

    // 0 means one byte; anything above bmax clamps to bmax.
    function automatic logic [2:0] norm_nbytes(input logic [2:0] nb, input int unsigned bmax);
        if (nb == 3'd0) return 3'd1;
        if ({29'd0, nb} > bmax) return 3'(bmax);
        return nb;
    endfunction

endpackage

// File: rtl/uart_io_unit_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO of 2**DEPTH_LOG2 entries. Full/empty come from the
// occupancy counter so a wrapped pointer pair is never ambiguous.
// A push while full is accepted only when a pop frees the slot in the same
// cycle; pops while empty are ignored.
//   clk, rst     clock, asynchronous active-high reset
//   push, din    write request and data
//   pop, dout    read request; dout shows the head entry (combinational)
//   count        occupancy, DEPTH_LOG2+1 bits
//   full, empty  occupancy status
// ---------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem_q[rd_ptr_q];
    assign count   = count_q;

    // Storage is not reset; pointers/count define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + DEPTH_LOG2'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + DEPTH_LOG2'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_io_unit.sv
// ---------------------------------------------------------------------------
// uart_io_unit
// Buffered UART byte-stream front end serving core IN/OUT instructions.
// RX bytes captured in EXEC mode are queued and assembled little-endian into
// 1..BYTES_MAX byte IN words; OUT words are split into bytes, queued and
// drained into uart_tx one start pulse at a time. In LOAD mode a single sync
// byte (0xAA) is queued and aa_sent reports when it has left the line.
//   clk, rst                 clock, asynchronous active-high reset
//   mode                     1=LOAD, 2=EXEC, other=idle
//   in_req/out_req, nbytes   transfer requests (pulses) and byte count
//   out_data / in_data       OUT word in, assembled IN word out
//   busy, done               core stall and one-cycle completion pulse
//   rx_data, rx_ready        byte stream from uart_rx
//   tx_data, tx_start, tx_busy  byte stream to uart_tx
//   aa_received, aa_sent     LOAD handshake status
//   rx_overflow, rx_count, tx_full  FIFO status
// ---------------------------------------------------------------------------
module uart_io_unit
    import uart_io_unit_pkg::*;
#(
    parameter int RX_DEPTH_LOG2 = 14,
    parameter int TX_DEPTH_LOG2 = 12,
    parameter int BYTES_MAX     = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [2:0]               mode,
    input  logic                     in_req,
    input  logic                     out_req,
    input  logic [2:0]               nbytes,
    input  logic [31:0]              out_data,
    output logic [31:0]              in_data,
    output logic                     busy,
    output logic                     done,
    input  logic [7:0]               rx_data,
    input  logic                     rx_ready,
    output logic [7:0]               tx_data,
    output logic                     tx_start,
    input  logic                     tx_busy,
    output logic                     aa_received,
    output logic                     aa_sent,
    output logic                     rx_overflow,
    output logic [RX_DEPTH_LOG2:0]   rx_count,
    output logic                     tx_full
);

    core_state_t state_q, state_d;
    tx_state_t   tx_state_q, tx_state_d;
    logic [2:0]  n_q, n_d, k_q, k_d;
    logic [31:0] acc_q, acc_d, word_q, word_d, in_data_q, in_data_d;
    logic        done_q, done_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        aa_queued_q, aa_sent_q, ovf_q;

    logic        rx_push, rx_pop, rx_full, rx_empty;
    logic [7:0]  rx_dout;
    logic        tx_push, tx_pop, tx_empty, out_push, aa_push;
    logic [7:0]  tx_din, tx_dout;
    logic [TX_DEPTH_LOG2:0] unused_tx_count;

    assign rx_push = (mode == MODE_EXEC) && rx_ready;

    // Sync byte takes the TX FIFO write port ahead of an OUT byte.
    assign aa_push = (mode == MODE_LOAD) && !aa_queued_q && !tx_full;
    assign tx_push = aa_push || out_push;
    assign tx_din  = aa_push ? SYNC_BYTE : word_q[{k_q[1:0], 3'b000} +: 8];

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(RX_DEPTH_LOG2)) u_rx_fifo (
        .clk(clk), .rst(rst), .push(rx_push), .pop(rx_pop), .din(rx_data),
        .dout(rx_dout), .count(rx_count), .full(rx_full), .empty(rx_empty)
    );

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(TX_DEPTH_LOG2)) u_tx_fifo (
        .clk(clk), .rst(rst), .push(tx_push), .pop(tx_pop), .din(tx_din),
        .dout(tx_dout), .count(unused_tx_count), .full(tx_full), .empty(tx_empty)
    );

    // Core transfer FSM
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        k_d       = k_q;
        acc_d     = acc_q;
        word_d    = word_q;
        in_data_d = in_data_q;
        done_d    = 1'b0;
        rx_pop    = 1'b0;
        out_push  = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_req) begin
                    state_d = IN_COLLECT;
                    n_d     = norm_nbytes(nbytes, BYTES_MAX);
                    k_d     = 3'd0;
                    acc_d   = '0;      // upper lanes stay zero for short reads
                end else if (out_req) begin
                    state_d = OUT_PUSH;
                    n_d     = norm_nbytes(nbytes, BYTES_MAX);
                    k_d     = 3'd0;
                    word_d  = out_data;
                end
            end
            IN_COLLECT: begin
                if (!rx_empty) begin
                    rx_pop = 1'b1;
                    acc_d[{k_q[1:0], 3'b000} +: 8] = rx_dout;
                    k_d = k_q + 3'd1;
                    if (k_d == n_q) begin
                        in_data_d = acc_d;
                        done_d    = 1'b1;
                        state_d   = IDLE;
                    end
                end
            end
            OUT_PUSH: begin
                if (!tx_full && !aa_push) begin
                    out_push = 1'b1;
                    k_d      = k_q + 3'd1;
                    if (k_d == n_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // TX drain FSM: the extra T_WAIT cycle gives uart_tx time to raise busy
    always_comb begin
        tx_state_d = tx_state_q;
        tx_data_d  = tx_data_q;
        tx_pop     = 1'b0;
        case (tx_state_q)
            T_IDLE: begin
                if (!tx_empty && !tx_busy) begin
                    tx_data_d  = tx_dout;
                    tx_pop     = 1'b1;
                    tx_state_d = T_START;
                end
            end
            T_START: tx_state_d = T_WAIT;
            T_WAIT:  tx_state_d = T_IDLE;
            default: tx_state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            tx_state_q  <= T_IDLE;
            n_q         <= '0;
            k_q         <= '0;
            acc_q       <= '0;
            word_q      <= '0;
            in_data_q   <= '0;
            done_q      <= 1'b0;
            tx_data_q   <= '0;
            aa_queued_q <= 1'b0;
            aa_sent_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            tx_state_q <= tx_state_d;
            n_q        <= n_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            word_q     <= word_d;
            in_data_q  <= in_data_d;
            done_q     <= done_d;
            tx_data_q  <= tx_data_d;
            if (aa_push) aa_queued_q <= 1'b1;
            // Sync byte is on the wire and finished once everything is idle.
            if (aa_queued_q && tx_empty && !tx_busy && tx_state_q == T_IDLE)
                aa_sent_q <= 1'b1;
            // A full RX FIFO still accepts a byte when a pop frees the slot.
            if (rx_push && rx_full && !rx_pop) ovf_q <= 1'b1;
        end
    end

    assign in_data     = in_data_q;
    assign done        = done_q;
    assign busy        = (state_q == IDLE && (in_req || out_req)) || (state_q != IDLE);
    assign tx_data     = tx_data_q;
    assign tx_start    = (tx_state_q == T_START);
    assign aa_received = rx_ready && (rx_data == SYNC_BYTE);
    assign aa_sent     = aa_sent_q;
    assign rx_overflow = ovf_q;

endmodule

// File: tb/tb_uart_io_unit.sv
module tb_uart_io_unit;

    localparam int RXL = 2;
    localparam int TXL = 3;
    localparam int BM  = 4;
    localparam int RXD = 1 << RXL;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    mode;
    logic          in_req, out_req;
    logic [2:0]    nbytes;
    logic [31:0]   out_data;
    logic [31:0]   in_data;
    logic          busy, done;
    logic [7:0]    rx_data;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_start;
    logic          tx_busy = 1'b0;
    logic          aa_received, aa_sent, rx_overflow;
    logic [RXL:0]  rx_count;
    logic          tx_full;

    uart_io_unit #(.RX_DEPTH_LOG2(RXL), .TX_DEPTH_LOG2(TXL), .BYTES_MAX(BM)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_req(in_req), .out_req(out_req),
        .nbytes(nbytes), .out_data(out_data), .in_data(in_data), .busy(busy),
        .done(done), .rx_data(rx_data), .rx_ready(rx_ready), .tx_data(tx_data),
        .tx_start(tx_start), .tx_busy(tx_busy), .aa_received(aa_received),
        .aa_sent(aa_sent), .rx_overflow(rx_overflow), .rx_count(rx_count),
        .tx_full(tx_full)
    );

    always #5 clk = ~clk;

    int           n_vec = 0;
    int           n_err = 0;
    byte unsigned rx_q[$];
    byte unsigned tx_exp[$];
    byte unsigned tx_seen[$];
    bit           ovf_exp;
    int           start_viol = 0;
    int           busy_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int norm(input int nb);
        if (nb == 0) return 1;
        if (nb > BM) return BM;
        return nb;
    endfunction

    // uart_tx stand-in: records each started byte and stays busy a few cycles
    always @(negedge clk) begin
        if (rst) begin
            tx_busy  = 1'b0;
            busy_cnt = 0;
        end else if (tx_start) begin
            tx_seen.push_back(tx_data);
            if (tx_busy) start_viol++;
            tx_busy  = 1'b1;
            busy_cnt = $urandom_range(2, 6);
        end else if (busy_cnt > 0) begin
            busy_cnt--;
            if (busy_cnt == 0) tx_busy = 1'b0;
        end
    end

    task automatic do_reset();
        rst = 1'b1; in_req = 1'b0; out_req = 1'b0; rx_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        rx_q.delete();
        ovf_exp = 1'b0;
        step();
    endtask

    task automatic rx_byte(input byte unsigned b);
        rx_data = b; rx_ready = 1'b1;
        #1;
        chk("aa_received", aa_received, (b == 8'hAA));
        step();
        rx_ready = 1'b0;
        if (mode == 3'd2) begin
            if (rx_q.size() < RXD) rx_q.push_back(b);
            else ovf_exp = 1'b1;
        end
    endtask

    // Caller guarantees the model already holds enough RX bytes.
    task automatic do_in(input int nb);
        int n, cnt;
        logic [31:0] want;
        bit got;
        n = norm(nb); want = '0;
        for (int i = 0; i < n; i++) want[8*i +: 8] = rx_q.pop_front();
        in_req = 1'b1; nbytes = 3'(nb);
        #1;
        chk("busy_on_req", busy, 1'b1);
        step();
        in_req = 1'b0;
        cnt = 0; got = 1'b0;
        while (!got && cnt < 50) begin step(); cnt++; if (done) got = 1'b1; end
        chk("in_done_seen", got, 1'b1);
        chk("in_latency", cnt, n);
        chk("in_data", in_data, want);
        chk("busy_at_done", busy, 1'b0);
        step();
        chk("done_pulse", done, 1'b0);
        chk("in_data_hold", in_data, want);
    endtask

    task automatic do_out(input logic [31:0] w, input int nb, input bit load_mid);
        int n, cnt;
        bit got;
        n = norm(nb);
        out_req = 1'b1; out_data = w; nbytes = 3'(nb);
        step();
        out_req = 1'b0;
        if (load_mid) begin mode = 3'd1; tx_exp.push_back(8'hAA); end
        for (int i = 0; i < n; i++) tx_exp.push_back(w[8*i +: 8]);
        cnt = 0; got = 1'b0;
        while (!got && cnt < 400) begin step(); cnt++; if (done) got = 1'b1; end
        chk("out_done_seen", got, 1'b1);
        chk("out_busy_at_done", busy, 1'b0);
    endtask

    task automatic drain_check(input string tag);
        int cnt;
        cnt = 0;
        while (tx_seen.size() < tx_exp.size() && cnt < 2000) begin step(); cnt++; end
        repeat (20) step();
        chk({tag, "_count"}, tx_seen.size(), tx_exp.size());
        for (int i = 0; i < tx_exp.size(); i++)
            if (i < tx_seen.size()) chk(tag, tx_seen[i], tx_exp[i]);
        chk("start_while_busy", start_viol, 0);
        tx_seen.delete();
        tx_exp.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cnt, nb, n;
        bit got;
        rst = 1'b1; mode = 3'd0; in_req = 1'b0; out_req = 1'b0; nbytes = 3'd0;
        out_data = '0; rx_data = '0; rx_ready = 1'b0;
        step(); step();
        chk("rst_in_data", in_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tx_start", tx_start, 0);
        chk("rst_aa_sent", aa_sent, 0);
        chk("rst_overflow", rx_overflow, 0);
        chk("rst_rx_count", rx_count, 0);
        chk("rst_tx_full", tx_full, 0);
        rst = 1'b0; ovf_exp = 1'b0;
        step();

        // 4-byte IN
        mode = 3'd2;
        rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33); rx_byte(8'h44);
        chk("rx_count4", rx_count, 4);
        do_in(4);
        chk("in_word_const", in_data, 32'h44332211);

        // 2-byte OUT
        do_out(32'hA1B2C3D4, 2, 1'b0);
        drain_check("tx_word");

        // overflow: five pushes into a four-entry FIFO
        for (int i = 0; i < 5; i++) rx_byte(8'($urandom));
        chk("ovf_count", rx_count, 4);
        chk("ovf_flag", rx_overflow, ovf_exp);
        do_in(4);
        chk("ovf_sticky", rx_overflow, 1'b1);

        // simultaneous requests, nbytes=0: IN of one byte wins
        rx_byte(8'h5C);
        in_req = 1'b1; out_req = 1'b1; nbytes = 3'd0; out_data = 32'hDEADBEEF;
        step();
        in_req = 1'b0; out_req = 1'b0;
        cnt = 0; got = 1'b0;
        while (!got && cnt < 20) begin step(); cnt++; if (done) got = 1'b1; end
        chk("both_done", got, 1'b1);
        chk("both_in_data", in_data, 32'h0000005C);
        void'(rx_q.pop_front());
        step();
        chk("both_idle", busy, 1'b0);
        drain_check("both_no_tx");

        // randomized traffic
        do_reset();
        mode = 3'd2;
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    mode = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'd2;
                    repeat ($urandom_range(1, 3))
                        rx_byte(($urandom_range(0, 3) == 0) ? 8'hAA : 8'($urandom));
                    mode = 3'd2;
                end
                1: begin
                    nb = $urandom_range(0, 7);
                    n  = norm(nb);
                    while (rx_q.size() < n) rx_byte(8'($urandom));
                    do_in(nb);
                end
                default: do_out($urandom, $urandom_range(0, 7), 1'b0);
            endcase
            chk("rand_rx_count", rx_count, rx_q.size());
            chk("rand_overflow", rx_overflow, ovf_exp);
        end
        drain_check("tx_rand");

        // LOAD sync byte from reset
        mode = 3'd0;
        do_reset();
        mode = 3'd1;
        cnt = 0;
        while (tx_seen.size() == 0 && cnt < 100) begin step(); cnt++; end
        chk("sync_seen", tx_seen.size(), 1);
        if (tx_seen.size() > 0) chk("sync_byte", tx_seen[0], 8'hAA);
        chk("aa_sent_early", aa_sent, 1'b0);
        cnt = 0;
        while (!aa_sent && cnt < 100) begin step(); cnt++; end
        chk("aa_sent_seen", aa_sent, 1'b1);
        chk("busy_low_at_aa_sent", tx_busy, 1'b0);
        repeat (30) step();
        chk("single_sync", tx_seen.size(), 1);
        chk("aa_sent_sticky", aa_sent, 1'b1);
        tx_seen.delete();

        // sync push collides with the first OUT push and wins
        mode = 3'd0;
        do_reset();
        do_out($urandom, 2, 1'b1);
        drain_check("load_prio");
        repeat (10) step();
        chk("load_prio_aa_sent", aa_sent, 1'b1);

        // reset in the middle of IN_COLLECT
        mode = 3'd0;
        do_reset();
        mode = 3'd2;
        rx_byte(8'h9A);
        do_in(1);
        rx_byte(8'h01); rx_byte(8'h02);
        in_req = 1'b1; nbytes = 3'd4;
        step();
        in_req = 1'b0;
        step(); step();
        rst = 1'b1;
        #1;
        chk("midrst_in_data", in_data, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_rx_count", rx_count, 0);
        rst = 1'b0;
        rx_q.delete();
        step();
        in_req = 1'b1; nbytes = 3'd1;
        step();
        in_req = 1'b0;
        for (int i = 0; i < 5; i++) begin step(); chk("midrst_wait", done, 1'b0); end
        chk("midrst_stall", busy, 1'b1);
        rx_byte(8'h7E);
        cnt = 0; got = 1'b0;
        while (!got && cnt < 10) begin if (done) got = 1'b1; else begin step(); cnt++; end end
        chk("midrst_done_seen", got, 1'b1);
        chk("midrst_new_byte", in_data, 32'h0000007E);
        rx_q.delete();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
